univ_shift_reg_n: RTL
=====================

Name: univ_shift_reg_n

Overview:
Parametrised successor to the 4-bit mode register. It is a WIDTH-bit universal shift/rotate register with parallel load and per-cycle single-step modes. It adds serial fill inputs and an auto-burst engine that performs N shifts under FSM control, with busy/done handshake. It sits in the datapath as a general staging/shift element for serialisers and alignment logic.

Parameters:
WIDTH, 8, data width (>=2)
AMT_W, 4, width of burst shift-amount input; max burst = 2^AMT_W-1

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset (reset==0 at a clk edge resets the block)
load  in  1  parallel load strobe
mode  in  2  00 hold, 01 shift left, 10 shift right, 11 rotate left
i  in  WIDTH  parallel load data
ser_l  in  1  fill bit entering MSB on shift right
ser_r  in  1  fill bit entering LSB on shift left
start  in  1  burst request
amt  in  AMT_W  burst step count
o  out  WIDTH  register contents
busy  out  1  burst in progress
done  out  1  one-cycle pulse after burst completes

Behaviour:
- Reset (reset==0 at edge): o=0, busy=0, done=0, state=IDLE, cnt=0. Reset overrides all other inputs, including mid-burst.
- Step function, combinational, applied at an edge:
  - 01: o <= {o[W-2:0], ser_r}
  - 10: o <= {ser_l, o[W-1:1]}
  - 11: o <= {o[W-2:0], o[W-1]}
  - 00: o unchanged
- State IDLE, priority load > start > mode:
  - load=1: o <= i next edge; start and mode are ignored that cycle.
  - start=1, amt!=0, mode!=00: latch mode into bmode and amt into cnt; go to SHIFT; busy <= 1. o is unchanged on this edge.
  - start=1 with amt==0 or mode==00: no shift; done <= 1 for one cycle; stay IDLE.
  - Otherwise: apply one step of the current mode (single-step operation, 1-cycle latency).
- State SHIFT:
  - Each edge: apply one step of bmode; cnt <= cnt-1.
  - On the edge where cnt==1: go to IDLE, busy <= 0, done <= 1.
  - load, start, mode, amt are ignored while busy=1.
  - ser_l and ser_r are sampled live each step.
- Burst timing: start accepted at edge 0. Shifts occur at edges 1..amt. done is high for the cycle after edge amt. busy is high from after edge 0 until edge amt.
- done is a single-cycle pulse, cleared on the next edge unless re-set.
- Back-to-back: start is accepted in the same cycle done is high. done still clears; busy re-asserts.
- Widths: cnt is AMT_W bits. amt > WIDTH is legal; shifts continue (a full rotate returns the original value after WIDTH steps).

Optional Feature:
Macro UNIV_SHIFT_REG_PARITY_EN.
- Defined: extra output port par (1 bit) = ^o, combinational from the register, so it is valid the same cycle as o; 0 during reset.
- Undefined: the par port does not exist; behaviour is otherwise identical.

Decomposition:
- Package univ_shift_reg_pkg:
  - mode constants MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_ROL=2'b11
  - FSM state type {ST_IDLE, ST_SHIFT}
- Sub-module shreg_step: purely combinational next-value function (mode, o, ser_l, ser_r -> next). It is reused by both the IDLE single-step path and the SHIFT path.

Test Plan (WIDTH=8, AMT_W=4):
1. Hold reset=0 for 2 edges, then release → o=8'h00, busy=0, done=0. Then load=1, i=8'hA5 → o=8'hA5 after 1 edge.
2. o=8'hA5, single-step: mode=01 with ser_r=1 → o=8'h4B. Next mode=10 with ser_l=0 → o=8'h25. Next mode=11 → o=8'h4A.
3. o=8'h81, start=1, mode=11, amt=3 → busy=1 for 3 cycles; o goes 03, 06, 0C. done=1 exactly one cycle after the third shift; busy=0.
4. During the step-3 burst, drive load=1 with i=8'hFF and mode=00 → ignored; final o=8'h0C.
5. Reset mid-burst (amt=10, reset=0 at the 4th shift edge) → o=0, busy=0, done never pulses. Separately, start with amt=0 → done pulses 1 cycle, o unchanged, busy stays 0.
6. With UNIV_SHIFT_REG_PARITY_EN defined: load 8'h07 → par=1; load 8'h03 → par=0. A rotate burst of 8 steps on 8'h07 → o=8'h07, par=1 throughout.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// Shared mode encodings and FSM state type for the universal shift register.
package univ_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_ROL  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/shreg_step.sv
// One-step next-value function for the shift register.
// Used for both single-step operation in IDLE and every step of a burst.
module shreg_step
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] o_i,
    input  logic             ser_l_i,
    input  logic             ser_r_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        next_o = o_i;
        case (mode_i)
            MODE_SHL: next_o = {o_i[WIDTH-2:0], ser_r_i};
            MODE_SHR: next_o = {ser_l_i, o_i[WIDTH-1:1]};
            MODE_ROL: next_o = {o_i[WIDTH-2:0], o_i[WIDTH-1]};
            default:  next_o = o_i;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_n.sv
// WIDTH-bit universal shift/rotate register with parallel load and an
// auto-burst engine. Optional parity output under UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg_n
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] i,
    input  logic             ser_l,
    input  logic             ser_r,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] o,
    output logic             busy,
    output logic             done
`ifdef UNIV_SHIFT_REG_PARITY_EN
    ,
    output logic             par
`endif
);

    state_e             state_q, state_d;
    logic [1:0]         bmode_q, bmode_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         step_mode;
    logic [WIDTH-1:0]   step_o;

    // A burst runs on the latched mode; IDLE single-steps follow the live mode.
    assign step_mode = (state_q == ST_SHIFT) ? bmode_q : mode;

    shreg_step #(.WIDTH(WIDTH)) u_step (
        .mode_i  (step_mode),
        .o_i     (o_q),
        .ser_l_i (ser_l),
        .ser_r_i (ser_r),
        .next_o  (step_o)
    );

    always_comb begin
        state_d = state_q;
        bmode_d = bmode_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    o_d = i;
                end else if (start) begin
                    if (amt != '0 && mode != MODE_HOLD) begin
                        state_d = ST_SHIFT;
                        bmode_d = mode;
                        cnt_d   = amt;
                        busy_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    o_d = step_o;
                end
            end
            ST_SHIFT: begin
                o_d   = step_o;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            bmode_q <= MODE_HOLD;
            cnt_q   <= '0;
            o_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bmode_q <= bmode_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o    = o_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef UNIV_SHIFT_REG_PARITY_EN
    // Forced low while reset is asserted, before the register has cleared.
    assign par = reset ? ^o_q : 1'b0;
`endif

endmodule
